uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 MSB-first transmitter used by the AES side-channel test link. It serialises a DATA_BITS-wide word with a configurable bit order, an optional parity bit and 1 or 2 stop bits. Bit timing comes from the external baud generator's s_tick, using TICKS_PER_BIT ticks per bit. It has a ready/valid input handshake and a one-cycle done pulse, and sits between the AES result buffer and the serial pin.

Parameters:
DATA_BITS, 8, payload width, legal range 5..9
TICKS_PER_BIT, 16, s_tick pulses per serial bit, legal range 1..64
STOP_BITS, 1, number of stop bits, 1 or 2
PARITY_MODE, 0, 0=none, 1=even, 2=odd
LSB_FIRST, 0, 1=LSB first (standard UART), 0=MSB first (legacy link)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
s_tick  in  1  baud tick, one clk cycle wide
tx_valid  in  1  word available on d_in
d_in  in  DATA_BITS  word to transmit
tx_ready  out  1  high when a word can be accepted
tx_done  out  1  one-cycle pulse after the last stop bit completes
busy  out  1  high from accept until the frame ends
tx  out  1  serial line, idle high

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, tx=1, tx_ready=1, tx_done=0, busy=0, all counters 0. Asserting reset mid-frame aborts the frame, and tx returns high immediately.
- tx is a registered output with no combinational path from the inputs.
- Handshake: a word is accepted on a clk edge where tx_valid && tx_ready. On that edge d_in goes to the shift register and the tick counter clears. tx_ready drops on the next cycle and stays low until the frame ends. d_in is ignored at all other times.
- State IDLE: tx=1. On accept, go to START.
- State START: tx=0. The tick counter increments on each s_tick. When the count reaches TICKS_PER_BIT-1 and s_tick is high, go to DATA with the counter=0 and bit index=0.
- State DATA: tx shows the current bit. With LSB_FIRST=1 this is shreg[0]; otherwise it is shreg[DATA_BITS-1].
  - At the end of each bit period the register shifts toward the output end.
  - After DATA_BITS bits, go to PARITY if PARITY_MODE!=0, otherwise go to STOP.
- State PARITY: tx = XOR of the accepted word for even parity, or its inverse for odd parity. Parity is computed from the word captured at accept, not from the shifted register. Lasts one bit period, then go to STOP.
- State STOP: tx=1 for STOP_BITS bit periods, then go to IDLE.
  - On the IDLE transition, tx_done pulses for exactly one clk and tx_ready rises on the same edge.
  - tx_done is never held high.
- Back-to-back frames: tx_valid held high with new data during the tx_done cycle is accepted one cycle later, with no idle bit inserted beyond STOP_BITS.
- busy = state != IDLE.
- Timing: s_tick is counted only in non-IDLE states. Ticks arriving in IDLE are ignored, so the start bit lasts at least TICKS_PER_BIT ticks.
- Frame length = (1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS) × TICKS_PER_BIT ticks.
- Counter widths: ceil(log2(TICKS_PER_BIT)) for the tick counter and ceil(log2(DATA_BITS)) for the bit index, minimum 1.
- An out-of-range parameter triggers an elaboration-time $error.

Optional Feature:
Macro UART_TX_BREAK_EN.
- Defined: adds input send_break (1). When send_break is high in IDLE, tx is driven 0 and tx_ready=0 for as long as it stays high. On release, the block waits one full bit period with tx=1 before tx_ready returns high. send_break is ignored while a frame is in progress.
- Not defined: the port is absent, and IDLE always drives tx=1.

Test Plan:
1. Defaults, TICKS_PER_BIT=16, s_tick every clk, d_in=8'hA5 -> tx: start 0 ×16, bits 1,0,1,0,0,1,0,1 ×16 each, stop 1 ×16. tx_done pulses once at cycle 160 after accept.
2. LSB_FIRST=1, PARITY_MODE=1, d_in=8'h03 -> data 1,1,0,0,0,0,0,0, then parity bit 0, then stop 1.
3. PARITY_MODE=2, STOP_BITS=2, DATA_BITS=7, d_in=7'h7F -> parity bit 0, then tx high for 32 ticks before tx_done.
4. tx_valid held high, data 8'h11 then 8'h22 -> the second start bit begins exactly at the end of the first stop period. tx_ready is low throughout each frame, and d_in changes mid-frame do not corrupt the output.
5. Assert reset during DATA bit 3 -> tx=1, tx_ready=1, busy=0 within the same cycle. The next frame transmits correctly.
6. UART_TX_BREAK_EN defined, send_break held high for 40 clk in IDLE -> tx=0 for 40 clk, then tx=1 for 16 ticks with tx_ready=0, then tx_ready=1. send_break asserted mid-frame has no effect.

Source files
------------

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: DATA_BITS payload, optional parity, 1/2 stop bits.
// Define UART_TX_BREAK_EN to add the send_break input (line break generation).
module uart_tx_param #(
    parameter int DATA_BITS     = 8,
    parameter int TICKS_PER_BIT = 16,
    parameter int STOP_BITS     = 1,
    parameter int PARITY_MODE   = 0,
    parameter int LSB_FIRST     = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_tick,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] d_in,
`ifdef UART_TX_BREAK_EN
    input  logic                 send_break,
`endif
    output logic                 tx_ready,
    output logic                 tx_done,
    output logic                 busy,
    output logic                 tx
);

    localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY_MODE == 2);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (TICKS_PER_BIT < 1 || TICKS_PER_BIT > 64) begin : g_bad_ticks
        $error("uart_tx_param: TICKS_PER_BIT must be 1..64");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
        $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
    end
    if (LSB_FIRST < 0 || LSB_FIRST > 1) begin : g_bad_order
        $error("uart_tx_param: LSB_FIRST must be 0 or 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK,
        HOLD
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [TW-1:0]        tick_cnt;
    logic [TW-1:0]        tick_n;
    logic [BW-1:0]        bit_idx;
    logic [BW-1:0]        bit_n;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_n;
    logic                 par;
    logic                 tx_n;
    logic                 done_n;
    logic                 accept;
    logic                 cnt_en;
    logic                 bit_end;

`ifdef UART_TX_BREAK_EN
    assign tx_ready = (state == IDLE) && !send_break;
`else
    assign tx_ready = (state == IDLE);
`endif

    assign accept  = tx_valid && tx_ready;
    assign busy    = !(state inside {IDLE, BREAK, HOLD});
    assign cnt_en  = state inside {START, DATA, PARITY, STOP, HOLD};
    assign bit_end = cnt_en && s_tick && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par      <= 1'b0;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_n;
            bit_idx  <= bit_n;
            shreg    <= shreg_n;
            tx       <= tx_n;
            tx_done  <= done_n;
            // parity comes from the word as accepted, not the shifted copy
            if (accept) begin
                par <= (^d_in) ^ ODD;
            end
        end
    end

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_idx;
        shreg_n = shreg;
        done_n  = 1'b0;

        if (cnt_en && s_tick) begin
            tick_n = bit_end ? '0 : tick_cnt + 1'b1;
        end

        unique case (state)
            IDLE: begin
`ifdef UART_TX_BREAK_EN
                if (send_break) begin
                    state_n = BREAK;
                end else
`endif
                if (accept) begin
                    state_n = START;
                    tick_n  = '0;
                    bit_n   = '0;
                    shreg_n = d_in;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    bit_n   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_n = (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);
                    if (bit_idx == BIT_LAST) begin
                        state_n = (PARITY_MODE != 0) ? PARITY : STOP;
                        bit_n   = '0;
                    end else begin
                        bit_n = bit_idx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    bit_n   = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_idx == STOP_LAST) begin
                        state_n = IDLE;
                        bit_n   = '0;
                        done_n  = 1'b1;
                    end else begin
                        bit_n = bit_idx + 1'b1;
                    end
                end
            end
            BREAK: begin
                tick_n = '0;
`ifdef UART_TX_BREAK_EN
                if (!send_break) begin
                    state_n = HOLD;
                end
`else
                state_n = IDLE;
`endif
            end
            HOLD: begin
                // one full idle-high bit period after a break releases
                if (bit_end) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // tx is computed from the next-state values so the pin is a pure flop
    always_comb begin
        tx_n = 1'b1;
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = (LSB_FIRST != 0) ? shreg_n[0] : shreg_n[DATA_BITS-1];
            PARITY:  tx_n = par;
            BREAK:   tx_n = 1'b0;
            default: tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: three parameter sets on a shared clock.
// Break tests build only when UART_TX_BREAK_EN is defined.
module tb_uart_tx_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_tick;
    logic       va, vb, vc;
    logic [7:0] da, db;
    logic [6:0] dc;
    logic       ra, rb, rc;
    logic       doa, dob, doc;
    logic       ba, bb, bc;
    logic       txa, txb, txc;
    logic       sb;

    int n_cmp = 0;
    int n_bad = 0;
    int sel   = 0;

    logic tx_s, done_s, rdy_s, busy_s;
    logic smp_tx   [0:399];
    logic smp_done [0:399];
    logic smp_rdy  [0:399];
    logic smp_busy [0:399];

    always #5 clk = ~clk;

    uart_tx_param dut_a (
        .clk(clk), .reset(reset), .s_tick(s_tick),
        .tx_valid(va), .d_in(da),
`ifdef UART_TX_BREAK_EN
        .send_break(sb),
`endif
        .tx_ready(ra), .tx_done(doa), .busy(ba), .tx(txa)
    );

    uart_tx_param #(.LSB_FIRST(1), .PARITY_MODE(1)) dut_b (
        .clk(clk), .reset(reset), .s_tick(s_tick),
        .tx_valid(vb), .d_in(db),
`ifdef UART_TX_BREAK_EN
        .send_break(1'b0),
`endif
        .tx_ready(rb), .tx_done(dob), .busy(bb), .tx(txb)
    );

    uart_tx_param #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) dut_c (
        .clk(clk), .reset(reset), .s_tick(s_tick),
        .tx_valid(vc), .d_in(dc),
`ifdef UART_TX_BREAK_EN
        .send_break(1'b0),
`endif
        .tx_ready(rc), .tx_done(doc), .busy(bc), .tx(txc)
    );

    always_comb begin
        tx_s = txa; done_s = doa; rdy_s = ra; busy_s = ba;
        if (sel == 1) begin
            tx_s = txb; done_s = dob; rdy_s = rb; busy_s = bb;
        end else if (sel == 2) begin
            tx_s = txc; done_s = doc; rdy_s = rc; busy_s = bc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic take(input int i);
        @(negedge clk);
        smp_tx[i]   = tx_s;
        smp_done[i] = done_s;
        smp_rdy[i]  = rdy_s;
        smp_busy[i] = busy_s;
    endtask

    task automatic launch(input int s, input logic [8:0] d, input bit hold);
        @(posedge clk);
        #1;
        sel = s;
        if (s == 0) begin va = 1'b1; da = d[7:0]; end
        if (s == 1) begin vb = 1'b1; db = d[7:0]; end
        if (s == 2) begin vc = 1'b1; dc = d[6:0]; end
        @(posedge clk);
        #1;
        if (!hold) begin
            va = 1'b0; vb = 1'b0; vc = 1'b0;
        end
    endtask

    function automatic int count_done(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i < hi; i++) c += int'(smp_done[i]);
        return c;
    endfunction

    task automatic check_frame(input string tag, input int base, input logic [15:0] bits,
                               input int nbits, input int done_rel);
        logic [15:0] got;
        int hi;
        for (int k = 0; k < nbits; k++) begin
            for (int j = 0; j < 16; j++) got[j] = smp_tx[base + 16*k + j];
            check($sformatf("%s bit%0d", tag, k), {16'h0, got},
                  bits[nbits-1-k] ? 32'hFFFF : 32'h0);
        end
        hi = 0;
        for (int i = base; i < base + done_rel; i++) hi += int'(smp_rdy[i]) + int'(smp_done[i]);
        check({tag, " rdy/done low in frame"}, hi, 0);
        check({tag, " busy"}, {31'h0, smp_busy[base]}, 1);
        check({tag, " done pulse"}, {31'h0, smp_done[base + done_rel]}, 1);
        check({tag, " rdy back"}, {31'h0, smp_rdy[base + done_rel]}, 1);
    endtask

    initial begin
        reset = 1'b1; s_tick = 1'b1; sb = 1'b0;
        va = 1'b0; vb = 1'b0; vc = 1'b0;
        da = '0; db = '0; dc = '0;
        repeat (3) @(negedge clk);
        check("rst tx", {31'h0, txa}, 1);
        check("rst ready", {31'h0, ra}, 1);
        check("rst busy", {31'h0, ba}, 0);
        check("rst done", {31'h0, doa}, 0);
        check("rst c tx/rdy", {30'h0, txc, rc}, 3);
        reset = 1'b0;

        // defaults, MSB first, A5
        launch(0, 9'h0A5, 1'b0);
        for (int i = 0; i < 170; i++) take(i);
        check_frame("t1", 0, 16'h014B, 10, 160);
        check("t1 done count", count_done(0, 170), 1);
        check("t1 idle after", {31'h0, smp_tx[169]}, 1);

        // LSB first, even parity, 03
        launch(1, 9'h003, 1'b0);
        for (int i = 0; i < 180; i++) take(i);
        check_frame("t2", 0, 16'h0301, 11, 176);
        check("t2 done count", count_done(0, 180), 1);

        // 7 data bits, odd parity, 2 stop bits, 7F
        launch(2, 9'h07F, 1'b0);
        for (int i = 0; i < 180; i++) take(i);
        check_frame("t3", 0, 16'h03FB, 11, 176);
        check("t3 done count", count_done(0, 180), 1);

        // back-to-back with d_in wiggling mid-frame
        launch(0, 9'h011, 1'b1);
        da = 8'h22;
        for (int i = 0; i < 340; i++) begin
            take(i);
            if (i == 50) da = 8'h5A;
            if (i == 100) da = 8'h22;
            if (i == 161) begin
                va = 1'b0;
                da = 8'hFF;
            end
        end
        check_frame("t4a", 0, 16'h0023, 10, 160);
        check_frame("t4b", 161, 16'h0045, 10, 160);
        check("t4 done count", count_done(0, 340), 2);

        // reset during data bit 3
        launch(0, 9'h0A5, 1'b0);
        for (int i = 0; i < 70; i++) take(i);
        check("t5 pre-reset tx", {31'h0, smp_tx[69]}, 0);
        reset = 1'b1;
        #1;
        check("t5 rst tx/rdy/busy", {29'h0, txa, ra, ba}, 3'b110);
        @(negedge clk);
        reset = 1'b0;
        launch(0, 9'h03C, 1'b0);
        for (int i = 0; i < 170; i++) take(i);
        check_frame("t5", 0, 16'h0079, 10, 160);

`ifdef UART_TX_BREAK_EN
        begin
            int zeros;
            sel = 0;
            @(posedge clk);
            #1;
            sb = 1'b1;
            for (int i = 0; i < 62; i++) begin
                take(i);
                if (i == 40) sb = 1'b0;
            end
            zeros = 0;
            for (int i = 0; i < 62; i++) zeros += int'(!smp_tx[i]);
            check("t6 break low clks", zeros, 40);
            check("t6 break edges", {29'h0, smp_tx[0], smp_tx[1], smp_tx[40]}, 3'b100);
            check("t6 hold high", {30'h0, smp_tx[41], smp_tx[56]}, 2'b11);
            check("t6 rdy low", {29'h0, smp_rdy[0], smp_rdy[40], smp_rdy[56]}, 0);
            check("t6 rdy back", {31'h0, smp_rdy[57]}, 1);
            launch(0, 9'h0A5, 1'b0);
            for (int i = 0; i < 170; i++) begin
                take(i);
                if (i == 50) sb = 1'b1;
                if (i == 155) sb = 1'b0;
            end
            check_frame("t6", 0, 16'h014B, 10, 160);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
